// File: rtl/spi_pixel_loader.sv
// SPI slave front end: deserialises commands and multi-channel pixels into framebuffer writes.
// Define SPI_PIXEL_LOADER_MISO_EN to shift the status byte out on miso during STATUS.
module spi_pixel_loader #(
  parameter int segments = 1,
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int channels = 3,
  parameter int bitwidth = 8,
  localparam int R  = segments * rows,
  localparam int RW = (R > 1) ? $clog2(R) : 1,
  localparam int CW = (columns > 1) ? $clog2(columns) : 1,
  localparam int PW = channels * bitwidth
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          ss,
  input  logic          mosi,
  output logic          miso,
  output logic [RW-1:0] wrow,
  output logic [CW-1:0] wcol,
  output logic [PW-1:0] wdata,
  output logic          wen,
  input  logic          ready,
  output logic          loaded
);

  localparam int CHW = (channels > 1) ? $clog2(channels) : 1;
  localparam logic [8:0]     R9       = 9'(R);
  localparam logic [8:0]     C9       = 9'(columns);
  localparam logic [RW-1:0]  ROW_LAST = RW'(R - 1);
  localparam logic [CW-1:0]  COL_LAST = CW'(columns - 1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(channels - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_AROW, S_ACOL, S_PIXEL, S_STATUS, S_DISCARD
  } state_t;

  state_t state_r, state_next_s;

  logic [2:0]     sclk_sync_r;
  logic [1:0]     ss_sync_r;
  logic [1:0]     mosi_sync_r;
  logic           ss_s, sclk_rise_s, byte_done_s;
  logic [7:0]     byte_s;
  logic [6:0]     shift_r;
  logic [2:0]     bit_cnt_r;

  logic           ptr_zero_s, ptr_load_s, row_capture_s, pix_byte_s;
  logic           commit_s, err_cmd_s, status_done_s, addr_ok_s;
  logic           pix_done_s, at_end_s;
  logic [7:0]     row_byte_r;
  logic [CHW-1:0] chan_r;
  logic [PW-1:0]  acc_r, acc_next_s;
  logic [bitwidth-1:0] pix_bits_s;
  logic [RW-1:0]  ptr_row_r;
  logic [CW-1:0]  ptr_col_r;
  logic           done_r, err_r;
  logic [7:0]     status_s;

  assign ss_s        = ss_sync_r[1];
  assign sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
  assign byte_s      = {shift_r, mosi_sync_r[1]};
  assign byte_done_s = ss_s & sclk_rise_s & (bit_cnt_r == 3'd7);
  assign addr_ok_s   = ({1'b0, row_byte_r} < R9) && ({1'b0, byte_s} < C9);
  assign pix_bits_s  = byte_s[7 -: bitwidth];
  assign acc_next_s  = PW'({acc_r, pix_bits_s});
  assign pix_done_s  = pix_byte_s && (chan_r == CH_LAST);
  assign at_end_s    = (ptr_row_r == ROW_LAST) && (ptr_col_r == COL_LAST);
  assign status_s    = {ready, done_r, err_r, 5'b00000};

  // Two-flop synchronisers; the third sclk stage feeds edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_r <= 3'b000;
      ss_sync_r   <= 2'b00;
      mosi_sync_r <= 2'b00;
    end else begin
      sclk_sync_r <= {sclk_sync_r[1:0], sclk};
      ss_sync_r   <= {ss_sync_r[0], ss};
      mosi_sync_r <= {mosi_sync_r[0], mosi};
    end
  end

  // Byte assembler: a partial byte is dropped whenever ss falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r   <= 7'd0;
      bit_cnt_r <= 3'd0;
    end else if (!ss_s) begin
      shift_r   <= 7'd0;
      bit_cnt_r <= 3'd0;
    end else if (sclk_rise_s) begin
      shift_r   <= byte_s[6:0];
      bit_cnt_r <= bit_cnt_r + 3'd1;
    end else begin
      shift_r   <= shift_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_next_s;
  end

  // FSM next state and per-byte control strobes.
  always_comb begin
    state_next_s  = state_r;
    ptr_zero_s    = 1'b0;
    ptr_load_s    = 1'b0;
    row_capture_s = 1'b0;
    pix_byte_s    = 1'b0;
    commit_s      = 1'b0;
    err_cmd_s     = 1'b0;
    status_done_s = 1'b0;
    if (!ss_s) begin
      state_next_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: state_next_s = S_CMD;
        S_CMD: begin
          if (byte_done_s) begin
            case (byte_s)
              8'hF0: begin ptr_zero_s = 1'b1; state_next_s = S_PIXEL; end
              8'hF1: state_next_s = S_AROW;
              8'hF2: state_next_s = S_STATUS;
              8'hF3: begin commit_s = 1'b1; state_next_s = S_DISCARD; end
              default: begin err_cmd_s = 1'b1; state_next_s = S_DISCARD; end
            endcase
          end else begin
            state_next_s = S_CMD;
          end
        end
        S_AROW: begin
          if (byte_done_s) begin
            row_capture_s = 1'b1;
            state_next_s  = S_ACOL;
          end else begin
            state_next_s  = S_AROW;
          end
        end
        S_ACOL: begin
          if (byte_done_s && addr_ok_s) begin
            ptr_load_s   = 1'b1;
            state_next_s = S_PIXEL;
          end else if (byte_done_s) begin
            err_cmd_s    = 1'b1;
            state_next_s = S_DISCARD;
          end else begin
            state_next_s = S_ACOL;
          end
        end
        S_PIXEL:   pix_byte_s    = byte_done_s;
        S_STATUS:  status_done_s = byte_done_s;
        S_DISCARD: state_next_s  = S_DISCARD;
        default:   state_next_s  = S_IDLE;
      endcase
    end
  end

  // Pixel assembly, pointer, framebuffer outputs and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_r     <= {CHW{1'b0}};
      acc_r      <= {PW{1'b0}};
      row_byte_r <= 8'd0;
      ptr_row_r  <= {RW{1'b0}};
      ptr_col_r  <= {CW{1'b0}};
      wrow       <= {RW{1'b0}};
      wcol       <= {CW{1'b0}};
      wdata      <= {PW{1'b0}};
      wen        <= 1'b0;
      loaded     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      if (state_r != S_PIXEL) begin
        chan_r <= {CHW{1'b0}};
        acc_r  <= {PW{1'b0}};
      end else if (pix_byte_s) begin
        chan_r <= (chan_r == CH_LAST) ? {CHW{1'b0}} : chan_r + CHW'(1);
        acc_r  <= acc_next_s;
      end

      if (row_capture_s) row_byte_r <= byte_s;

      if (ptr_zero_s) begin
        ptr_row_r <= {RW{1'b0}};
        ptr_col_r <= {CW{1'b0}};
      end else if (ptr_load_s) begin
        ptr_row_r <= row_byte_r[RW-1:0];
        ptr_col_r <= byte_s[CW-1:0];
      end else if (pix_done_s) begin
        if (ptr_col_r == COL_LAST) begin
          ptr_col_r <= {CW{1'b0}};
          ptr_row_r <= (ptr_row_r == ROW_LAST) ? {RW{1'b0}} : ptr_row_r + RW'(1);
        end else begin
          ptr_col_r <= ptr_col_r + CW'(1);
        end
      end

      // Address is latched even when ready is low so a stalled pixel still consumes its slot.
      wen    <= pix_done_s & ready;
      loaded <= commit_s | (pix_done_s & at_end_s);
      if (pix_done_s) begin
        wrow  <= ptr_row_r;
        wcol  <= ptr_col_r;
        wdata <= acc_next_s;
      end

      if (pix_done_s && at_end_s) done_r <= 1'b1;
      else if (status_done_s)     done_r <= 1'b0;
      if (err_cmd_s || (pix_done_s && !ready)) err_r <= 1'b1;
      else if (status_done_s)                  err_r <= 1'b0;
    end
  end

`ifdef SPI_PIXEL_LOADER_MISO_EN
  logic [7:0] status_sr_r;
  logic       sclk_fall_s;
  assign sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2];

  // Status shifter: bit7 appears at byte completion, later bits on falling edges within a byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_sr_r <= 8'd0;
      miso        <= 1'b0;
    end else if (state_next_s != S_STATUS) begin
      status_sr_r <= 8'd0;
      miso        <= 1'b0;
    end else if (state_r == S_CMD) begin
      status_sr_r <= status_s;
      miso        <= status_s[7];
    end else if (status_done_s) begin
      status_sr_r <= {ready, 7'b0000000};
      miso        <= ready;
    end else if (sclk_fall_s && (bit_cnt_r != 3'd0)) begin
      status_sr_r <= {status_sr_r[6:0], 1'b0};
      miso        <= status_sr_r[6];
    end else begin
      status_sr_r <= status_sr_r;
      miso        <= miso;
    end
  end
`else
  // No readback path: the flags still record but miso is held low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) miso <= 1'b0;
    else     miso <= (|status_s) & 1'b0;
  end
`endif

endmodule

// File: tb/tb_spi_pixel_loader.sv
// Scoreboard bench for spi_pixel_loader: SPI master stimulus, queue of expected writes/commits.
module tb_spi_pixel_loader;
  localparam int R = 8;
  localparam int C = 32;

  logic clk = 1'b0;
  logic rst, sclk, ss, mosi, miso, wen, ready, loaded;
  logic [2:0]  wrow;
  logic [4:0]  wcol;
  logic [23:0] wdata;

  spi_pixel_loader dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .wrow(wrow), .wcol(wcol), .wdata(wdata), .wen(wen), .ready(ready), .loaded(loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          commit;
    int          row;
    int          col;
    logic [23:0] data;
    bit          ld;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   mp       = 0;
  bit   mdone    = 1'b0;
  bit   merr     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every wen or loaded pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && (wen === 1'b1 || loaded === 1'b1)) begin
      if (expq.size() == 0) begin
        check("unexpected_output", 32'({wen, loaded}), 32'd0);
      end else begin
        mon_e = expq.pop_front();
        if (mon_e.commit) begin
          check("commit_wen", 32'(wen), 32'd0);
          check("commit_loaded", 32'(loaded), 32'd1);
        end else begin
          check("wen", 32'(wen), 32'd1);
          check("wrow", 32'(wrow), mon_e.row);
          check("wcol", 32'(wcol), mon_e.col);
          check("wdata", 32'(wdata), 32'(mon_e.data));
          check("loaded_with_wen", 32'(loaded), 32'(mon_e.ld));
        end
      end
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      repeat (4) @(negedge clk);
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    logic [7:0] d;
    spi_bits(b, 8, d);
  endtask

  task automatic ss_on();
    ss = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic ss_off();
    mosi = 1'b0;
    ss   = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cmd_f0();
    spi_byte(8'hF0);
    mp = 0;
  endtask

  task automatic cmd_f1(input int row, input int col);
    spi_byte(8'hF1);
    spi_byte(8'(row));
    spi_byte(8'(col));
    if (row < R && col < C) mp = row * C + col;
    else merr = 1'b1;
  endtask

  // Reference: linear pointer over R*C pixels; ready low drops the write and flags an error.
  task automatic pixel(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_t e;
    if (ready) begin
      e.commit = 1'b0;
      e.row    = mp / C;
      e.col    = mp % C;
      e.data   = {a, b, c};
      e.ld     = (mp == R * C - 1);
      expq.push_back(e);
    end else begin
      merr = 1'b1;
    end
    if (mp == R * C - 1) mdone = 1'b1;
    mp = (mp + 1) % (R * C);
    spi_byte(a);
    spi_byte(b);
    spi_byte(c);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 8 * expq.size() + 16;
    while (expq.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (4) @(negedge clk);
    check(name, 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  task automatic read_status(input string name);
    logic [7:0] rx, e;
    ss_on();
    spi_byte(8'hF2);
    spi_bits(8'h00, 8, rx);
`ifdef SPI_PIXEL_LOADER_MISO_EN
    e = {1'b1, mdone, merr, 5'b00000};
`else
    e = 8'h00;
`endif
    check(name, 32'(rx), 32'(e));
    mdone = 1'b0;
    merr  = 1'b0;
    ss_off();
    check({name, "_miso_idle"}, 32'(miso), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wen"}, 32'(wen), 32'd0);
    check({tag, "_loaded"}, 32'(loaded), 32'd0);
    check({tag, "_wrow"}, 32'(wrow), 32'd0);
    check({tag, "_wcol"}, 32'(wcol), 32'd0);
    check({tag, "_wdata"}, 32'(wdata), 32'd0);
    check({tag, "_miso"}, 32'(miso), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    exp_t ce;
    rst = 1'b1; sclk = 1'b0; ss = 1'b0; mosi = 1'b0; ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: two pixels from (0,0)
    ss_on();
    cmd_f0();
    pixel(8'hFF, 8'hFF, 8'hFF);
    pixel(8'hFF, 8'h00, 8'hFF);
    drain("t1_drain");
    ss_off();

    // 2: full frame with wrap, then one more pixel at (0,0)
    ss_on();
    cmd_f0();
    for (int p = 0; p < R * C; p++) begin
      if (p == R * C - 1) pixel(8'h00, 8'hED, 8'(p % C));
      else pixel(8'($urandom), 8'($urandom), 8'(p % C));
    end
    pixel(8'h12, 8'h34, 8'h56);
    drain("t2_drain");
    ss_off();

    // 3: windowed start, then an out-of-range address
    ss_on();
    cmd_f1(3, 30);
    pixel(8'($urandom), 8'($urandom), 8'($urandom));
    pixel(8'($urandom), 8'($urandom), 8'($urandom));
    drain("t3_drain");
    ss_off();
    ss_on();
    cmd_f1(8, 0);
    drain("t3_bad_addr");
    ss_off();

    // 4: aborted pixel leaves no write; resume by address
    ss_on();
    cmd_f0();
    spi_byte(8'hFF);
    spi_byte(8'hFF);
    begin
      logic [7:0] d;
      spi_bits(8'hFF, 4, d);
    end
    ss_off();
    ss_on();
    cmd_f1(0, 5);
    pixel(8'hAA, 8'hBB, 8'hCC);
    drain("t4_drain");
    ss_off();

    // random windows
    for (int k = 0; k < 4; k++) begin
      int n;
      ss_on();
      cmd_f1($urandom_range(0, R - 1), $urandom_range(0, C - 1));
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) pixel(8'($urandom), 8'($urandom), 8'($urandom));
      drain("rand_drain");
      ss_off();
    end

    // 5: stalled pixel, then status reads
    ss_on();
    cmd_f0();
    ready = 1'b0;
    pixel(8'($urandom), 8'($urandom), 8'($urandom));
    ready = 1'b1;
    pixel(8'h01, 8'h23, 8'h45);
    drain("t5_drain");
    ss_off();
    mdone = 1'b1;
    read_status("t5_status1");
    read_status("t5_status2");

    // 6: commit, then reset mid-pixel
    ss_on();
    ce.commit = 1'b1; ce.row = 0; ce.col = 0; ce.data = 24'h0; ce.ld = 1'b1;
    expq.push_back(ce);
    spi_byte(8'hF3);
    drain("t6_commit");
    ss_off();
    ss_on();
    cmd_f0();
    spi_byte(8'h01);
    spi_byte(8'h02);
    begin
      logic [7:0] d;
      spi_bits(8'h03, 3, d);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    ss = 1'b0;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mp = 0; mdone = 1'b0; merr = 1'b0;
    repeat (3) @(negedge clk);
    read_status("t6_status_after_reset");
    ss_on();
    cmd_f0();
    pixel(8'h01, 8'h02, 8'h03);
    drain("t6_drain");
    ss_off();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
